f20_result_framer: RTL and testbench
====================================

Name: f20_result_framer

Overview:
- Sits directly downstream of the 20-bit reduced-float multiplier (DN × background-subtracted coefficient).
- Captures each result on the multiplier's rdy strobe and tags it with column/row position and line/frame markers.
- Buffers results in a small first-word-fall-through FIFO and drives a valid/ready stream to the next consumer.
- Flags non-finite results and FIFO overflow through sticky error bits that feed the top-level error output.

Parameters:
- N_COL, 16, pixels per row; must be ≥2.
- N_ROW, 8, rows per frame; must be ≥1.
- DEPTH_LOG2, 3, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_rdy  in  1  result strobe from the multiplier; one result per high cycle.
- in_data  in  20  reduced float: [19] sign, [18:11] exponent (bias 127), [10:0] mantissa.
- out_valid  out  1  FIFO head holds a sample.
- out_ready  in  1  consumer accepts the head sample.
- out_data  out  20  reduced-float sample at the FIFO head.
- out_col  out  clog2(N_COL)  column tag of the head sample.
- out_row  out  clog2(N_ROW)  row tag of the head sample.
- out_eol  out  1  head sample is the last column of its row.
- out_eof  out  1  head sample is the last pixel of the frame.
- fifo_count  out  DEPTH_LOG2+1  current occupancy, 0..depth.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.
- nan_seen  out  1  sticky; a result with exponent 8'hFF was captured.
- error  out  1  overflow OR nan_seen.

Behaviour:
- Reset (async, any time, including mid-frame):
  - Clears read/write pointers, fifo_count, the column/row counters, overflow and nan_seen.
  - All outputs read 0 while reset is high and on the first edge after release.
  - FIFO contents are don't-care after reset; out_data must read 0 whenever out_valid = 0.
- Push:
  - A push is requested on every edge where in_rdy = 1.
  - The stored entry is {in_data, col_ctr, row_ctr, eol, eof}.
  - eol = (col_ctr == N_COL-1).
  - eof = eol AND (row_ctr == N_ROW-1).
- Position counters:
  - Advance on every in_rdy, including dropped samples, so frame geometry stays aligned to the multiplier stream.
  - col_ctr wraps N_COL-1 → 0 and increments row_ctr on wrap.
  - row_ctr wraps N_ROW-1 → 0.
- Pop: occurs on an edge where out_valid = 1 and out_ready = 1.
- Latency and output timing:
  - FWFT: a push into an empty FIFO at edge k gives out_valid = 1 with the pushed data/tags in the cycle after edge k (1-cycle latency).
  - out_valid = (fifo_count != 0).
  - Head outputs change only after a pop or after a push into an empty FIFO.
- Full FIFO (fifo_count == depth):
  - Push with a simultaneous pop: both occur; count stays at depth; no overflow.
  - Push with no pop: sample discarded, overflow set, count unchanged.
- Empty FIFO: out_ready is ignored and no pop occurs; a simultaneous push is accepted normally.
- Simultaneous push and pop when not full and not empty: count unchanged; pointers both advance.
- Pointer wrap: pointers are DEPTH_LOG2 bits and wrap naturally modulo depth.
- Non-finite detection:
  - nan_seen is set on any captured in_rdy sample with in_data[18:11] == 8'hFF (Inf or NaN).
  - The check applies even if the sample is dropped for overflow.
  - The sample still passes through unmodified.
- Sticky bits clear only on reset. error is combinational OR of registered bits.
- No internal back-pressure to the multiplier: it cannot stall, so overflow is the only loss mechanism.

Test Plan:
- Reset release, then in_rdy pulse with in_data = 20'h40400 (3.0) and out_ready = 1 → next cycle out_valid = 1, out_data = 20'h40400, col 0, row 0; popped at following edge; fifo_count returns to 0.
- Stream 16×8 = 128 consecutive results with out_ready = 1 → out_eol on cols 15 only; out_eof only on sample 128 (row 7, col 15); sample 129 tagged col 0, row 0.
- out_ready = 0, 9 consecutive pushes → fifo_count = 8, overflow = 1, error = 1; draining returns the first 8 samples in order; the 10th push is tagged col 9.
- At full, in_rdy = 1 and out_ready = 1 for 20 cycles → fifo_count stays 8, no overflow, data in strict FIFO order.
- Push in_data = 20'h7F800 (+Inf), then 20'h7FC00 (NaN) → nan_seen = 1 after the first; both samples delivered unchanged.
- Mid-frame (row 3, col 5), 3 entries queued, assert reset for one cycle → out_valid = 0, fifo_count = 0, sticky bits 0; next push tagged col 0, row 0.

Source files
------------

// File: rtl/f20_result_framer.sv
// Tags each multiplier result with its frame position and buffers it in a
// small FWFT FIFO feeding a valid/ready stream; sticky flags for loss and Inf/NaN.
module f20_result_framer #(
  parameter  int N_COL      = 16,
  parameter  int N_ROW      = 8,
  parameter  int DEPTH_LOG2 = 3,
  localparam int CW         = (N_COL > 1) ? $clog2(N_COL) : 1,
  localparam int RW         = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_rdy,
  input  logic [19:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [19:0]           out_data,
  output logic [CW-1:0]         out_col,
  output logic [RW-1:0]         out_row,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  nan_seen,
  output logic                  error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [19:0]   data;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          eol;
    logic          eof;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic                  r_ovf;
  logic                  r_nan;
  logic                  r_run;

  logic   w_push_req;
  logic   w_push;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;
  logic   w_eol;
  logic   w_eof;
  logic   w_nonfinite;
  entry_t w_new;
  entry_t w_head;

  // The first edge after reset release only arms the block, so every output
  // is still zero after it even if the multiplier strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_run <= 1'b0;
    else       r_run <= 1'b1;
  end

  assign w_push_req  = in_rdy & r_run;
  assign w_full      = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = ~w_empty & out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_eol       = (r_col == CW'(N_COL-1));
  assign w_eof       = w_eol & (r_row == RW'(N_ROW-1));
  assign w_nonfinite = (in_data[18:11] == 8'hFF);

  always_comb begin
    w_new      = '0;
    w_new.data = in_data;
    w_new.col  = r_col;
    w_new.row  = r_row;
    w_new.eol  = w_eol;
    w_new.eof  = w_eof;
  end

  // Storage needs no reset: nothing is visible unless the count says so.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Geometry follows every strobe, dropped or not, to stay frame-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_push_req) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_nan <= 1'b0;
    end else begin
      if (w_push_req & w_full & ~w_pop) r_ovf <= 1'b1;
      if (w_push_req & w_nonfinite)     r_nan <= 1'b1;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = ~w_empty;
  assign out_data   = out_valid ? w_head.data : '0;
  assign out_col    = out_valid ? w_head.col  : '0;
  assign out_row    = out_valid ? w_head.row  : '0;
  assign out_eol    = out_valid & w_head.eol;
  assign out_eof    = out_valid & w_head.eof;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
  assign nan_seen   = r_nan;
  assign error      = r_ovf | r_nan;

endmodule

// File: tb/tb_f20_result_framer.sv
// Directed bench for f20_result_framer: hand-computed tags, FIFO order, sticky flags.
module tb_f20_result_framer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_rdy = 1'b0;
  logic [19:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;
  logic [3:0]  out_col;
  logic [2:0]  out_row;
  logic        out_eol;
  logic        out_eof;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        nan_seen;
  logic        error;

  int n_chk = 0;
  int n_err = 0;

  f20_result_framer dut (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_row(out_row), .out_eol(out_eol), .out_eof(out_eof),
    .fifo_count(fifo_count), .overflow(overflow), .nan_seen(nan_seen), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [19:0] d, input int c, input int r);
    return {3'b0, d, 4'(c), 3'(r), (c == 15), (c == 15 && r == 7)};
  endfunction

  function automatic logic [31:0] head();
    return {3'b0, out_data, out_col, out_row, out_eol, out_eof};
  endfunction

  function automatic logic [31:0] all_outs();
    return {10'b0, out_valid, out_data, out_col, out_row, out_eol, out_eof,
            fifo_count, overflow, nan_seen, error} & 32'hFFFF_FFFF;
  endfunction

  task automatic do_reset();
    in_rdy = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_async", {out_valid, fifo_count, overflow, nan_seen, error}, '0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_first_edge", {out_valid, out_data, fifo_count, error}, '0);
    tick();
  endtask

  initial begin
    #1;
    chk("rst_outs", {out_valid, out_data, out_col, out_row, out_eol, out_eof,
                     fifo_count, overflow, nan_seen, error}, '0);
    tick();

    // single sample, 1-cycle FWFT latency, popped next edge
    do_reset();
    out_ready = 1'b1; in_rdy = 1'b1; in_data = 20'h40400;
    tick();
    in_rdy = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_head", head(), mk(20'h40400, 0, 0));
    chk("t1_cnt", fifo_count, 1);
    tick();
    chk("t1_cnt_after", fifo_count, 0);
    chk("t1_data_zero", {out_valid, out_data}, 0);

    // full frame plus one with continuous drain
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 129; i++) begin
      in_rdy = 1'b1; in_data = 20'h00100 + 20'(i);
      tick();
      chk($sformatf("t2_s%0d", i), {out_valid, head()},
          {1'b1, mk(20'h00100 + 20'(i), i % 16, (i / 16) % 8)});
    end
    in_rdy = 1'b0;
    tick();
    chk("t2_empty", fifo_count, 0);

    // overflow: 9 pushes into stalled FIFO
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_rdy = 1'b1; in_data = 20'h10000 + 20'(i);
      tick();
      if (i == 7) chk("t3_full_no_ovf", {fifo_count, overflow}, {4'd8, 1'b0});
    end
    chk("t3_cnt", fifo_count, 8);
    chk("t3_ovf_err", {overflow, error}, 2'b11);
    in_data = 20'h10009; out_ready = 1'b1;
    chk("t3_head0", head(), mk(20'h10000, 0, 0));
    tick();
    in_rdy = 1'b0;
    chk("t3_cnt_pushpop", fifo_count, 8);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (k < 7) ? k + 1 : 9;
      chk($sformatf("t3_drain%0d", k), head(), mk(20'h10000 + 20'(c), c, 0));
      tick();
    end
    chk("t3_drained", {out_valid, fifo_count}, 0);

    // sustained push+pop at full
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_rdy = 1'b1; in_data = 20'h20000 + 20'(i);
      tick();
    end
    chk("t4_full", fifo_count, 8);
    for (int j = 0; j < 20; j++) begin
      in_rdy = 1'b1; in_data = 20'h20000 + 20'(j + 8); out_ready = 1'b1;
      chk($sformatf("t4_head%0d", j), head(), mk(20'h20000 + 20'(j), j % 16, j / 16));
      tick();
      chk($sformatf("t4_cnt%0d", j), fifo_count, 8);
    end
    in_rdy = 1'b0;
    chk("t4_no_ovf", overflow, 0);
    for (int j = 20; j < 28; j++) begin
      chk($sformatf("t4_tail%0d", j), head(), mk(20'h20000 + 20'(j), j % 16, j / 16));
      tick();
    end
    chk("t4_empty", out_valid, 0);

    // Inf then NaN pass through and set nan_seen
    do_reset();
    out_ready = 1'b0;
    chk("t5_nan_clr", nan_seen, 0);
    in_rdy = 1'b1; in_data = 20'h7F800;
    tick();
    chk("t5_nan_inf", {nan_seen, error, overflow}, 3'b110);
    in_data = 20'h7FC00;
    tick();
    in_rdy = 1'b0; out_ready = 1'b1;
    chk("t5_inf_out", head(), mk(20'h7F800, 0, 0));
    tick();
    chk("t5_nan_out", head(), mk(20'h7FC00, 1, 0));
    tick();
    chk("t5_empty", out_valid, 0);

    // mid-frame reset at row 3 col 5 with 3 entries queued
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_rdy = 1'b1; in_data = 20'h00001 + 20'(i);
      tick();
    end
    in_rdy = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 50; i < 53; i++) begin
      in_rdy = 1'b1; in_data = (i == 52) ? 20'h7F800 : 20'h00001 + 20'(i);
      tick();
    end
    in_rdy = 1'b0;
    chk("t6_queued", {fifo_count, nan_seen}, {4'd3, 1'b1});
    chk("t6_head", head(), mk(20'h00033, 2, 3));
    do_reset();
    chk("t6_after_rst", {out_valid, fifo_count, overflow, nan_seen, error}, '0);
    in_rdy = 1'b1; in_data = 20'h12345;
    tick();
    in_rdy = 1'b0;
    chk("t6_retag", {out_valid, head()}, {1'b1, mk(20'h12345, 0, 0)});
    chk("t6_cnt", fifo_count, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
